// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the I/D-cache to memory-bus arbiter.
//   state_t  : transaction FSM states
//   owner_t  : which cache currently holds the bus
//   READ_BIT : tag bit that marks a request as a read (1) or a write (0)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned WORDSIZE_DEF = 64;
    localparam int unsigned TAGWIDTH_DEF = 13;
    localparam int unsigned BEATS_DEF    = 8;
    localparam int unsigned READ_BIT     = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_READ_RESP,
        S_WRITE_DATA
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Request/response handshake bundle used on both the cache side and the
// memory side of the arbiter.
//   reqcyc/req/reqtag : request beat (address first, write data after)
//   reqack            : request beat accepted
//   respcyc/resp/resptag : response beat
//   respack           : response beat consumed
// Modports:
//   master : issues requests, consumes responses
//   slave  : accepts requests, produces responses
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORDSIZE = WORDSIZE_DEF,
    parameter int unsigned TAGWIDTH = TAGWIDTH_DEF
);
    logic                reqcyc;
    logic [WORDSIZE-1:0] req;
    logic [TAGWIDTH-1:0] reqtag;
    logic                reqack;
    logic                respcyc;
    logic [WORDSIZE-1:0] resp;
    logic [TAGWIDTH-1:0] resptag;
    logic                respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant between the I-cache and D-cache.
//   clk, reset : clock, synchronous active-high reset
//   req_i/req_d: request lines
//   take       : the current grant is being consumed this cycle
//   valid      : at least one requester
//   grant      : winning requester
// On a tie the pointer decides; after each consumed grant the pointer moves
// to the other requester. Reset favours the D-cache.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   take,
    output logic   valid,
    output owner_t grant
);
    owner_t prio;

    always_comb begin
        valid = req_i | req_d;
        if (req_i && req_d) begin
            grant = prio;
        end else if (req_d) begin
            grant = OWN_D;
        end else begin
            grant = OWN_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= OWN_D;
        end else if (take && valid) begin
            prio <= other_owner(grant);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory bus between an I-cache and a D-cache. A transaction is an
// address beat followed by BEATS read-response or write-data beats; the bus
// stays locked to one cache for the whole transaction.
//   clk, reset : clock, synchronous active-high reset
//   icache     : I-cache port (slave side of the handshake)
//   dcache     : D-cache port (slave side of the handshake)
//   bus        : memory port (master side of the handshake)
// Request and response paths are combinational pass-throughs to the owner;
// the non-owner sees all-zero outputs.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORDSIZE = WORDSIZE_DEF,
    parameter int unsigned TAGWIDTH = TAGWIDTH_DEF,
    parameter int unsigned BEATS    = BEATS_DEF
)(
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  icache,
    mem_arbiter_if.slave  dcache,
    mem_arbiter_if.master bus
);
    localparam int unsigned      CNTW = $clog2(BEATS) + 1;
    localparam logic [CNTW-1:0]  LAST = CNTW'(BEATS - 1);

    state_t          state;
    owner_t          owner;      // meaningful only outside S_IDLE
    logic [CNTW-1:0] count;
    logic            read_txn;   // READ flag captured at grant

    logic   gnt_valid;
    owner_t gnt;
    logic   in_idle;

    assign in_idle = (state == S_IDLE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i (icache.reqcyc),
        .req_d (dcache.reqcyc),
        .take  (in_idle),
        .valid (gnt_valid),
        .grant (gnt)
    );

    // Owner-side request/response signals
    logic                own_reqcyc;
    logic [WORDSIZE-1:0] own_req;
    logic [TAGWIDTH-1:0] own_reqtag;
    logic                own_respack;
    logic                req_phase;
    logic                resp_phase;
    logic                own_i;
    logic                own_d;
    logic                req_beat;
    logic                resp_beat;

    always_comb begin
        own_reqcyc  = (owner == OWN_D) ? dcache.reqcyc  : icache.reqcyc;
        own_req     = (owner == OWN_D) ? dcache.req     : icache.req;
        own_reqtag  = (owner == OWN_D) ? dcache.reqtag  : icache.reqtag;
        own_respack = (owner == OWN_D) ? dcache.respack : icache.respack;
        req_phase   = (state == S_ADDR) || (state == S_WRITE_DATA);
        resp_phase  = (state == S_READ_RESP);
        own_i       = !in_idle && (owner == OWN_I);
        own_d       = !in_idle && (owner == OWN_D);
        req_beat    = req_phase && own_reqcyc && bus.reqack;
        resp_beat   = resp_phase && bus.respcyc && own_respack;
    end

    assign bus.reqcyc   = req_phase && own_reqcyc;
    assign bus.req      = req_phase ? own_req    : '0;
    assign bus.reqtag   = req_phase ? own_reqtag : '0;
    assign bus.respack  = resp_phase && own_respack;

    assign icache.reqack  = req_phase && own_i && bus.reqack;
    assign dcache.reqack  = req_phase && own_d && bus.reqack;
    assign icache.respcyc = resp_phase && own_i && bus.respcyc;
    assign dcache.respcyc = resp_phase && own_d && bus.respcyc;
    assign icache.resp    = (resp_phase && own_i) ? bus.resp    : '0;
    assign dcache.resp    = (resp_phase && own_d) ? bus.resp    : '0;
    assign icache.resptag = (resp_phase && own_i) ? bus.resptag : '0;
    assign dcache.resptag = (resp_phase && own_d) ? bus.resptag : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= OWN_D;
            count    <= '0;
            read_txn <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        owner    <= gnt;
                        read_txn <= (gnt == OWN_D) ? dcache.reqtag[READ_BIT]
                                                   : icache.reqtag[READ_BIT];
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (req_beat) begin
                        count <= '0;
                        state <= read_txn ? S_READ_RESP : S_WRITE_DATA;
                    end
                end
                S_READ_RESP: begin
                    if (resp_beat) begin
                        if (count == LAST) begin
                            count <= '0;
                            state <= S_IDLE;
                        end else begin
                            count <= count + CNTW'(1);
                        end
                    end
                end
                S_WRITE_DATA: begin
                    // A dropped reqcyc simply stalls here; there is no timeout.
                    if (req_beat) begin
                        if (count == LAST) begin
                            count <= '0;
                            state <= S_IDLE;
                        end else begin
                            count <= count + CNTW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a vector table for a lone D-cache read,
// directed sequences for arbitration, writes and reset, then randomized
// traffic compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned W = 64;
    localparam int unsigned T = 13;
    localparam int unsigned B = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WORDSIZE(W), .TAGWIDTH(T)) ic ();
    mem_arbiter_if #(.WORDSIZE(W), .TAGWIDTH(T)) dc ();
    mem_arbiter_if #(.WORDSIZE(W), .TAGWIDTH(T)) bus ();

    mem_arbiter #(.WORDSIZE(W), .TAGWIDTH(T), .BEATS(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .icache (ic),
        .dcache (dc),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        ic.reqcyc = 0; ic.req = '0; ic.reqtag = '0; ic.respack = 0;
        dc.reqcyc = 0; dc.req = '0; dc.reqtag = '0; dc.respack = 0;
        bus.reqack = 0; bus.respcyc = 0; bus.resp = '0; bus.resptag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_req(input bit is_d, input logic cyc, input logic [63:0] a, input logic [12:0] t);
        if (is_d) begin dc.reqcyc = cyc; dc.req = a; dc.reqtag = t; end
        else      begin ic.reqcyc = cyc; ic.req = a; ic.reqtag = t; end
    endtask

    task automatic set_respack(input bit is_d, input logic v);
        if (is_d) dc.respack = v; else ic.respack = v;
    endtask

    function automatic logic reqack_of(input bit is_d);
        return is_d ? dc.reqack : ic.reqack;
    endfunction

    function automatic logic respcyc_of(input bit is_d);
        return is_d ? dc.respcyc : ic.respcyc;
    endfunction

    function automatic logic [63:0] resp_of(input bit is_d);
        return is_d ? dc.resp : ic.resp;
    endfunction

    // Full read transaction starting from IDLE, with is_d expected to win.
    task automatic serve_read(input bit is_d, input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] base);
        drive_req(is_d, 1'b1, addr, tag);
        bus.reqack = 0;
        settle();
        chk("idle_no_bus_reqcyc", bus.reqcyc, 1'b0);
        tick();
        settle();
        chk("addr_bus_reqcyc", bus.reqcyc, 1'b1);
        chk("addr_bus_req", bus.req, addr);
        chk("addr_bus_reqtag", bus.reqtag, 64'(tag));
        chk("addr_stall_reqack", reqack_of(is_d), 1'b0);
        tick();
        bus.reqack = 1;
        settle();
        chk("addr_owner_reqack", reqack_of(is_d), 1'b1);
        chk("addr_other_reqack", reqack_of(!is_d), 1'b0);
        tick();
        bus.reqack = 0;
        drive_req(is_d, 1'b0, '0, '0);
        for (int k = 0; k < int'(B); k++) begin
            bus.respcyc = 1; bus.resp = base + 64'(k); bus.resptag = tag;
            if (k == 3) begin
                set_respack(is_d, 1'b0);
                settle();
                chk("rd_stall_bus_respack", bus.respack, 1'b0);
                chk("rd_stall_owner_respcyc", respcyc_of(is_d), 1'b1);
                tick();
            end
            set_respack(is_d, 1'b1);
            settle();
            chk("rd_owner_respcyc", respcyc_of(is_d), 1'b1);
            chk("rd_owner_resp", resp_of(is_d), base + 64'(k));
            chk("rd_other_respcyc", respcyc_of(!is_d), 1'b0);
            chk("rd_other_reqack", reqack_of(!is_d), 1'b0);
            chk("rd_bus_respack", bus.respack, 1'b1);
            chk("rd_bus_reqcyc", bus.reqcyc, 1'b0);
            tick();
        end
        bus.respcyc = 0;
        set_respack(is_d, 1'b0);
    endtask

    // Vector table: lone D-cache read then a stray response pulse in IDLE.
    typedef struct {
        logic        dcyc;
        logic [63:0] dreq;
        logic [12:0] dtag;
        logic        back;
        logic        rcyc;
        logic [63:0] rdata;
        logic        dack;
        logic        e_bcyc;
        logic [63:0] e_breq;
        logic        e_dreqack;
        logic        e_drcyc;
        logic [63:0] e_dresp;
        logic        e_brack;
    } vec_t;

    vec_t tbl[$];

    // Reference model: transaction-level view of who owns the bus and how
    // many data beats remain.
    int m_own;   // -1 none, 0 icache, 1 dcache
    int m_pref;  // requester that wins a tie
    int m_stage; // 0 waiting for address accept, 1 read data, 2 write data
    bit m_read;
    int m_left;

    task automatic model_check();
        logic        ocyc, oack;
        logic [63:0] oreq;
        logic [12:0] otag;
        logic        reqside, respside;
        ocyc = (m_own == 1) ? dc.reqcyc : ic.reqcyc;
        oreq = (m_own == 1) ? dc.req : ic.req;
        otag = (m_own == 1) ? dc.reqtag : ic.reqtag;
        oack = (m_own == 1) ? dc.respack : ic.respack;
        reqside  = (m_own >= 0) && (m_stage != 1);
        respside = (m_own >= 0) && (m_stage == 1);
        chk("rnd_bus_reqcyc", bus.reqcyc, reqside && ocyc);
        chk("rnd_bus_req", bus.req, reqside ? oreq : 64'd0);
        chk("rnd_bus_reqtag", bus.reqtag, reqside ? 64'(otag) : 64'd0);
        chk("rnd_bus_respack", bus.respack, respside && oack);
        chk("rnd_i_reqack", ic.reqack, reqside && m_own == 0 && bus.reqack);
        chk("rnd_d_reqack", dc.reqack, reqside && m_own == 1 && bus.reqack);
        chk("rnd_i_respcyc", ic.respcyc, respside && m_own == 0 && bus.respcyc);
        chk("rnd_d_respcyc", dc.respcyc, respside && m_own == 1 && bus.respcyc);
        chk("rnd_i_resp", ic.resp, (respside && m_own == 0) ? bus.resp : 64'd0);
        chk("rnd_d_resp", dc.resp, (respside && m_own == 1) ? bus.resp : 64'd0);
        chk("rnd_i_resptag", ic.resptag, (respside && m_own == 0) ? 64'(bus.resptag) : 64'd0);
        chk("rnd_d_resptag", dc.resptag, (respside && m_own == 1) ? 64'(bus.resptag) : 64'd0);
    endtask

    task automatic model_step();
        logic ocyc, oack;
        ocyc = (m_own == 1) ? dc.reqcyc : ic.reqcyc;
        oack = (m_own == 1) ? dc.respack : ic.respack;
        if (reset) begin
            m_own = -1;
            m_pref = 1;
        end else if (m_own < 0) begin
            if (ic.reqcyc || dc.reqcyc) begin
                m_own   = (ic.reqcyc && dc.reqcyc) ? m_pref : (dc.reqcyc ? 1 : 0);
                m_pref  = 1 - m_own;
                m_read  = (m_own == 1) ? dc.reqtag[12] : ic.reqtag[12];
                m_stage = 0;
            end
        end else if (m_stage == 0) begin
            if (ocyc && bus.reqack) begin
                m_stage = m_read ? 1 : 2;
                m_left  = int'(B);
            end
        end else if (m_stage == 1) begin
            if (bus.respcyc && oack) begin
                m_left--;
                if (m_left == 0) m_own = -1;
            end
        end else begin
            if (ocyc && bus.reqack) begin
                m_left--;
                if (m_left == 0) m_own = -1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();

        // Reset state with live inputs: nothing may leak through.
        dc.reqcyc = 1; dc.req = 64'h1000; dc.reqtag = 13'h1005;
        bus.respcyc = 1; dc.respack = 1; bus.reqack = 1;
        tick();
        settle();
        chk("rst_bus_reqcyc", bus.reqcyc, 1'b0);
        chk("rst_bus_respack", bus.respack, 1'b0);
        chk("rst_d_reqack", dc.reqack, 1'b0);
        chk("rst_d_respcyc", dc.respcyc, 1'b0);
        chk("rst_i_respcyc", ic.respcyc, 1'b0);
        clear_inputs();
        tick();
        reset = 1'b0;

        // Lone D read 0x1000, tag READ|5, then bus_respcyc pulse in IDLE.
        tbl.push_back('{1'b1, 64'h1000, 13'h1005, 1'b0, 1'b0, 64'h0, 1'b0,
                        1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0});
        tbl.push_back('{1'b1, 64'h1000, 13'h1005, 1'b1, 1'b0, 64'h0, 1'b0,
                        1'b1, 64'h1000, 1'b1, 1'b0, 64'h0, 1'b0});
        for (int k = 0; k < int'(B); k++)
            tbl.push_back('{1'b0, 64'h0, 13'h0, 1'b0, 1'b1, 64'(k), 1'b1,
                            1'b0, 64'h0, 1'b0, 1'b1, 64'(k), 1'b1});
        tbl.push_back('{1'b0, 64'h0, 13'h0, 1'b0, 1'b1, 64'h55, 1'b1,
                        1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0});
        foreach (tbl[r]) begin
            dc.reqcyc = tbl[r].dcyc; dc.req = tbl[r].dreq; dc.reqtag = tbl[r].dtag;
            bus.reqack = tbl[r].back; bus.respcyc = tbl[r].rcyc;
            bus.resp = tbl[r].rdata; bus.resptag = 13'h1005; dc.respack = tbl[r].dack;
            settle();
            chk($sformatf("vec%0d_bus_reqcyc", r), bus.reqcyc, tbl[r].e_bcyc);
            chk($sformatf("vec%0d_bus_req", r), bus.req, tbl[r].e_breq);
            chk($sformatf("vec%0d_d_reqack", r), dc.reqack, tbl[r].e_dreqack);
            chk($sformatf("vec%0d_d_respcyc", r), dc.respcyc, tbl[r].e_drcyc);
            chk($sformatf("vec%0d_d_resp", r), dc.resp, tbl[r].e_dresp);
            chk($sformatf("vec%0d_bus_respack", r), bus.respack, tbl[r].e_brack);
            chk($sformatf("vec%0d_i_respcyc", r), ic.respcyc, 1'b0);
            tick();
        end
        clear_inputs();
        tick();

        // Collisions after reset: D, then I, then D again; I waits during D read.
        do_reset();
        drive_req(1'b0, 1'b1, 64'h3000, 13'h1001);
        serve_read(1'b1, 64'h1100, 13'h1002, 64'h100);
        serve_read(1'b0, 64'h3000, 13'h1001, 64'h200);
        drive_req(1'b0, 1'b1, 64'h3300, 13'h1003);
        serve_read(1'b1, 64'h1200, 13'h1004, 64'h300);
        serve_read(1'b0, 64'h3300, 13'h1003, 64'h400);
        clear_inputs();
        tick();

        // D write 0x2040: address beat, 8 data beats 0xA0..0xA7.
        drive_req(1'b1, 1'b1, 64'h2040, 13'h0007);
        settle();
        chk("wr_idle_bus_reqcyc", bus.reqcyc, 1'b0);
        tick();
        bus.reqack = 1;
        settle();
        chk("wr_addr_bus_reqcyc", bus.reqcyc, 1'b1);
        chk("wr_addr_bus_req", bus.req, 64'h2040);
        chk("wr_addr_bus_reqtag", bus.reqtag, 64'h7);
        chk("wr_addr_d_reqack", dc.reqack, 1'b1);
        chk("wr_addr_i_reqack", ic.reqack, 1'b0);
        tick();
        for (int k = 0; k < int'(B); k++) begin
            dc.req = 64'hA0 + 64'(k);
            if (k == 2) begin
                bus.reqack = 0;
                settle();
                chk("wr_stall_bus_req", bus.req, 64'hA0 + 64'(k));
                chk("wr_stall_d_reqack", dc.reqack, 1'b0);
                tick();
                bus.reqack = 1;
            end
            if (k == 5) begin
                dc.reqcyc = 0;
                settle();
                chk("wr_drop_bus_reqcyc", bus.reqcyc, 1'b0);
                chk("wr_drop_d_reqack", dc.reqack, 1'b1);
                tick();
                dc.reqcyc = 1;
            end
            settle();
            chk("wr_data_bus_reqcyc", bus.reqcyc, 1'b1);
            chk("wr_data_bus_req", bus.req, 64'hA0 + 64'(k));
            chk("wr_data_d_reqack", dc.reqack, 1'b1);
            tick();
        end
        dc.req = 64'hEE;
        bus.reqack = 0;
        settle();
        chk("wr_done_idle_bus_reqcyc", bus.reqcyc, 1'b0);
        clear_inputs();
        tick();

        // Reset during read beat 4, then a fresh I read.
        drive_req(1'b1, 1'b1, 64'h4000, 13'h1009);
        tick();
        bus.reqack = 1;
        tick();
        bus.reqack = 0;
        drive_req(1'b1, 1'b0, '0, '0);
        bus.respcyc = 1; dc.respack = 1;
        for (int k = 0; k < 4; k++) begin
            bus.resp = 64'(k);
            tick();
        end
        bus.resp = 64'd4;
        reset = 1'b1;
        settle();
        chk("rst_mid_beat4_d_respcyc", dc.respcyc, 1'b1);
        tick();
        reset = 1'b0;
        settle();
        chk("rst_mid_d_respcyc", dc.respcyc, 1'b0);
        chk("rst_mid_d_resp", dc.resp, 64'd0);
        chk("rst_mid_bus_respack", bus.respack, 1'b0);
        chk("rst_mid_bus_reqcyc", bus.reqcyc, 1'b0);
        chk("rst_mid_d_reqack", dc.reqack, 1'b0);
        clear_inputs();
        serve_read(1'b0, 64'h5000, 13'h100A, 64'h500);
        clear_inputs();
        tick();

        // Randomized traffic against the reference model.
        reset = 1'b1;
        model_step();
        tick();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(199) == 0);
            ic.reqcyc   = 1'($urandom_range(1));
            ic.req      = {$urandom(), $urandom()};
            ic.reqtag   = 13'($urandom());
            ic.respack  = ($urandom_range(9) < 7);
            dc.reqcyc   = 1'($urandom_range(1));
            dc.req      = {$urandom(), $urandom()};
            dc.reqtag   = 13'($urandom());
            dc.respack  = ($urandom_range(9) < 7);
            bus.reqack  = ($urandom_range(9) < 6);
            bus.respcyc = ($urandom_range(9) < 6);
            bus.resp    = {$urandom(), $urandom()};
            bus.resptag = 13'($urandom());
            settle();
            model_check();
            model_step();
            tick();
        end
        reset = 1'b0;
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
